// File: rtl/prirv32_dmem_resp.sv
// priRV32 data-memory responder: word SRAM, configurable wait states, store byte lanes, load extraction.
// Define PRIRV32_DMEM_ERR_EN to flag illegal accesses; otherwise accesses are force-aligned and wrap.
module prirv32_dmem_resp #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [1:0]  dbg_state_o
);
    // Handshakes: a request transfers on a clock edge where req_valid_i && req_ready_o;
    // a response transfers on an edge where rsp_valid_o && rsp_ready_i, and is held stable until then.
    localparam int          DEPTH = 1 << ADDR_WIDTH;
    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_WAIT = 2'd1;
    localparam logic [1:0]  S_RESP = 2'd2;
    localparam logic [3:0]  WS     = WAIT_STATES[3:0];

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_we;
    logic        r_unsigned;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic        w_idle;
    logic        w_accept;
    logic        w_enter_resp;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [1:0]  w_size_raw;
    logic [1:0]  w_size;
    logic        w_we;
    logic        w_uns;
    logic [31:0] w_offset;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [1:0]  w_lane;
    logic        w_err;
    logic [3:0]  w_be;
    logic [31:0] w_wrep;
    logic [31:0] w_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ldata;

    assign w_idle       = (r_state == S_IDLE);
    assign w_accept     = req_valid_i && w_idle;
    assign w_enter_resp = (w_accept && (WAIT_STATES == 0)) || ((r_state == S_WAIT) && (r_cnt == 4'd1));

    // With no wait states RESP is entered on the accept edge, so fields come straight from the inputs.
    assign w_addr     = w_idle ? req_addr_i     : r_addr;
    assign w_wdata    = w_idle ? req_wdata_i    : r_wdata;
    assign w_size_raw = w_idle ? req_size_i     : r_size;
    assign w_we       = w_idle ? req_we_i       : r_we;
    assign w_uns      = w_idle ? req_unsigned_i : r_unsigned;
    assign w_size     = (w_size_raw == 2'b11) ? 2'b10 : w_size_raw;

    assign w_offset = w_addr - BASE_ADDR;
    assign w_idx    = w_offset[ADDR_WIDTH+1:2];
    assign w_lane   = w_offset[1:0];

`ifdef PRIRV32_DMEM_ERR_EN
    assign w_err = (w_size_raw == 2'b11)
                || ((w_size_raw == 2'b01) && w_addr[0])
                || ((w_size_raw == 2'b10) && (w_addr[1:0] != 2'b00))
                || ({1'b0, w_offset} >= (33'd4 << ADDR_WIDTH));
`else
    logic w_unused_hi;
    assign w_err       = 1'b0;
    assign w_unused_hi = ^w_offset[31:ADDR_WIDTH+2];
`endif

    always_comb begin
        w_be   = 4'b1111;
        w_wrep = w_wdata;
        case (w_size)
            2'b00: begin
                w_be   = 4'b0001 << w_lane;
                w_wrep = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be   = 4'b0011 << {w_lane[1], 1'b0};
                w_wrep = {2{w_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_lane, 3'b000} +: 8];
    assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_ldata = w_word;
        case (w_size)
            2'b00:   w_ldata = {{24{~w_uns & w_byte[7]}}, w_byte};
            2'b01:   w_ldata = {{16{~w_uns & w_half[15]}}, w_half};
            default: ;
        endcase
    end

    // Stores commit only on the edge entering RESP; a reset on that edge drops them.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_enter_resp && w_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wrep[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr     <= req_addr_i;
                r_wdata    <= req_wdata_i;
                r_size     <= req_size_i;
                r_we       <= req_we_i;
                r_unsigned <= req_unsigned_i;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (WAIT_STATES == 0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= WS;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_state <= S_IDLE;
                        r_rdata <= 32'd0;
                        r_err   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_enter_resp) begin
                r_rdata <= (w_we || w_err) ? 32'd0 : w_ldata;
                r_err   <= w_err;
            end
        end
    end

    assign req_ready_o = w_idle;
    assign rsp_valid_o = (r_state == S_RESP);
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_prirv32_dmem_resp.sv
// Directed bench for prirv32_dmem_resp: byte-addressed memory model with a per-cycle compare process.
module tb_prirv32_dmem_resp;
    localparam int          AW   = 10;
    localparam int          WS   = 1;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] SPAN = 32'd4 << AW;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [1:0]  dbg_state_o;

    prirv32_dmem_resp #(.ADDR_WIDTH(AW), .WAIT_STATES(WS), .BASE_ADDR(BASE)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_addr_i     (req_addr_i),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .dbg_state_o    (dbg_state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    logic [31:0] last_rdata;
    logic        last_err;

    typedef struct {
        logic [31:0] off;
        logic        we;
        int          n;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] bm [0:4095];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Model: memory as plain bytes; a request touches n consecutive bytes at its offset.
    function automatic void model_eval(input logic [31:0] a, input logic we, input logic [1:0] sz,
                                       input logic uns, output logic [31:0] rd, output logic e,
                                       output logic [31:0] off, output int n);
        logic [31:0] o;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        o = a - BASE;
`ifdef PRIRV32_DMEM_ERR_EN
        e = (sz == 2'd3) || ((a % n) != 0) || (o >= SPAN);
`else
        e = 1'b0;
        o = o % SPAN;
        o = o - (o % n);
`endif
        off = e ? 32'd0 : o;
        rd  = 32'd0;
        if (!e && !we) begin
            for (int i = 0; i < n; i++) rd = rd | (32'(bm[off + i]) << (8 * i));
            if (!uns && n < 4 && rd[8*n-1]) rd = rd | ~((32'd1 << (8 * n)) - 32'd1);
        end
    endfunction

    // scoreboard / compare process
    always @(negedge clk_i) begin
        logic exp_ready;
        logic exp_valid;
        if (chk_en) begin
            exp_ready = (exp_q.size() == 0);
            exp_valid = !exp_ready && (cyc >= exp_q[0].due);
            chk("req_ready", {31'd0, req_ready_o}, {31'd0, exp_ready});
            chk("rsp_valid", {31'd0, rsp_valid_o}, {31'd0, exp_valid});
            if (exp_valid) begin
                chk("rsp_rdata", rsp_rdata_o, exp_q[0].rdata);
                chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, exp_q[0].err});
                if (rsp_ready_i) begin
                    if (exp_q[0].we && !exp_q[0].err)
                        for (int i = 0; i < exp_q[0].n; i++) bm[exp_q[0].off + i] = exp_q[0].wdata[8*i +: 8];
                    last_rdata = rsp_rdata_o;
                    last_err   = rsp_err_o;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // driver
    task automatic do_req(input logic [31:0] a, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] wd, input logic [31:0] lit_rd, input logic lit_err,
                          input int hold, input bit rst_wait);
        exp_t e;
        int   acc;
        bit   ok;
        if (hold > 0) rsp_ready_i = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_i);
            if (req_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("timeout_ready", 32'd0, 32'd1);
        req_valid_i = 1'b1; req_addr_i = a; req_we_i = we; req_size_i = sz;
        req_unsigned_i = uns; req_wdata_i = wd;
        acc = cyc;
        @(posedge clk_i);
        model_eval(a, we, sz, uns, e.rdata, e.err, e.off, e.n);
        e.we = we; e.wdata = wd; e.due = acc + 1 + WS;
        exp_q.push_back(e);
        #1;
        req_valid_i = 1'b0;
        req_addr_i = $urandom_range(32'hFFFF, 0);
        if (rst_wait) begin
            rst_i = 1'b1;
            @(posedge clk_i);
            #1;
            rst_i = 1'b0;
            exp_q.delete();
            @(negedge clk_i);
            chk("rst_dbg_state", {30'd0, dbg_state_o}, 32'd0);
            chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
            return;
        end
        if (hold > 0) begin
            ok = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk_i);
                if (rsp_valid_o) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) chk("timeout_hold", 32'd0, 32'd1);
            for (int k = 0; k < hold; k++) begin
                chk("hold_valid", {31'd0, rsp_valid_o}, 32'd1);
                chk("hold_rdata", rsp_rdata_o, lit_rd);
                chk("hold_ready", {31'd0, req_ready_o}, 32'd0);
                @(negedge clk_i);
            end
            @(posedge clk_i);
            #1;
            rsp_ready_i = 1'b1;
        end
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk_i);
            #2;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("timeout_rsp", 32'd0, 32'd1);
            exp_q.delete();
        end else begin
            chk("lit_rdata", last_rdata, lit_rd);
            chk("lit_err", {31'd0, last_err}, {31'd0, lit_err});
        end
    endtask

    initial begin
        rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = 32'd0; req_we_i = 1'b0;
        req_size_i = 2'd0; req_unsigned_i = 1'b0; req_wdata_i = 32'd0; rsp_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("reset_ready", {31'd0, req_ready_o}, 32'd1);
        chk("reset_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("reset_rdata", rsp_rdata_o, 32'd0);
        chk("reset_err", {31'd0, rsp_err_o}, 32'd0);
        chk("reset_state", {30'd0, dbg_state_o}, 32'd0);
        chk_en = 1'b1;

        //     addr          we    size  uns   wdata          lit_rdata      err   hold rst
        do_req(32'h10,       1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0,         1'b0, 0, 1'b0);
        do_req(32'h10,       1'b0, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF,  1'b0, 0, 1'b0);
        do_req(32'h0,        1'b1, 2'd2, 1'b0, 32'hCAFEF00D, 32'h0,         1'b0, 0, 1'b0);
        do_req(32'h13,       1'b1, 2'd0, 1'b0, 32'h00000080, 32'h0,         1'b0, 0, 1'b0);
        do_req(32'h13,       1'b0, 2'd0, 1'b0, 32'h0,        32'hFFFFFF80,  1'b0, 0, 1'b0);
        do_req(32'h13,       1'b0, 2'd0, 1'b1, 32'h0,        32'h00000080,  1'b0, 0, 1'b0);
        do_req(32'h10,       1'b0, 2'd2, 1'b0, 32'h0,        32'h80ADBEEF,  1'b0, 0, 1'b0);
        do_req(32'h20,       1'b1, 2'd2, 1'b0, 32'h11223344, 32'h0,         1'b0, 0, 1'b0);
        do_req(32'h22,       1'b1, 2'd1, 1'b0, 32'h00008001, 32'h0,         1'b0, 0, 1'b0);
        do_req(32'h22,       1'b0, 2'd1, 1'b0, 32'h0,        32'hFFFF8001,  1'b0, 0, 1'b0);
        do_req(32'h22,       1'b0, 2'd1, 1'b1, 32'h0,        32'h00008001,  1'b0, 0, 1'b0);
        do_req(32'h20,       1'b0, 2'd2, 1'b0, 32'h0,        32'h80013344,  1'b0, 0, 1'b0);
        do_req(32'h21,       1'b0, 2'd0, 1'b1, 32'h0,        32'h00000033,  1'b0, 0, 1'b0);
`ifdef PRIRV32_DMEM_ERR_EN
        do_req(32'h11,       1'b0, 2'd2, 1'b0, 32'h0,        32'h0,         1'b1, 0, 1'b0);
        do_req(32'h21,       1'b1, 2'd1, 1'b0, 32'h0000AAAA, 32'h0,         1'b1, 0, 1'b0);
        do_req(32'h20,       1'b0, 2'd3, 1'b0, 32'h0,        32'h0,         1'b1, 0, 1'b0);
        do_req(32'h1000,     1'b0, 2'd2, 1'b0, 32'h0,        32'h0,         1'b1, 0, 1'b0);
        do_req(32'h1000,     1'b1, 2'd2, 1'b0, 32'hBADBAD00, 32'h0,         1'b1, 0, 1'b0);
        do_req(32'h20,       1'b0, 2'd2, 1'b0, 32'h0,        32'h80013344,  1'b0, 0, 1'b0);
        do_req(32'h0,        1'b0, 2'd2, 1'b0, 32'h0,        32'hCAFEF00D,  1'b0, 0, 1'b0);
`else
        do_req(32'h11,       1'b0, 2'd2, 1'b0, 32'h0,        32'h80ADBEEF,  1'b0, 0, 1'b0);
        do_req(32'h21,       1'b1, 2'd1, 1'b0, 32'h0000AAAA, 32'h0,         1'b0, 0, 1'b0);
        do_req(32'h20,       1'b0, 2'd3, 1'b0, 32'h0,        32'h8001AAAA,  1'b0, 0, 1'b0);
        do_req(32'h1000,     1'b0, 2'd2, 1'b0, 32'h0,        32'hCAFEF00D,  1'b0, 0, 1'b0);
        do_req(32'h20,       1'b0, 2'd2, 1'b0, 32'h0,        32'h8001AAAA,  1'b0, 0, 1'b0);
`endif
        do_req(32'h10,       1'b0, 2'd2, 1'b0, 32'h0,        32'h80ADBEEF,  1'b0, 5, 1'b0);
        do_req(32'h40,       1'b1, 2'd2, 1'b0, 32'h55AA55AA, 32'h0,         1'b0, 0, 1'b0);
        do_req(32'h40,       1'b1, 2'd2, 1'b0, 32'h12345678, 32'h0,         1'b0, 0, 1'b1);
        do_req(32'h40,       1'b0, 2'd2, 1'b0, 32'h0,        32'h55AA55AA,  1'b0, 0, 1'b0);
        do_req(32'h42,       1'b0, 2'd1, 1'b0, 32'h0,        32'h000055AA,  1'b0, 0, 1'b0);

        repeat (3) @(posedge clk_i);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
